// File: rtl/mesh_nn_accelerator.sv
// Mesh-attached dot-product node: STORE packets fill local memory, START runs a signed MAC
// over mem[0..N-1] x mem[H..H+N-1] and emits one result packet. Optional macro: MESH_NN_RELU_EN.
module mesh_nn_accelerator #(
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 10,
  localparam int pkt_width_lp  = 2 + addr_width_p + data_width_p + 2*x_cord_width_p + 2*y_cord_width_p,
  localparam int link_width_lp = pkt_width_lp + 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [link_width_lp-1:0]  link_sif_i,
  output logic [link_width_lp-1:0]  link_sif_o,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  output logic                      finish_o
);

  localparam int x_lp = x_cord_width_p;
  localparam int y_lp = y_cord_width_p;
  localparam int d_lp = data_width_p;
  localparam int a_lp = addr_width_p;

  localparam int dst_x_lsb_lp = 0;
  localparam int dst_y_lsb_lp = x_lp;
  localparam int src_x_lsb_lp = x_lp + y_lp;
  localparam int src_y_lsb_lp = 2*x_lp + y_lp;
  localparam int data_lsb_lp  = 2*x_lp + 2*y_lp;
  localparam int addr_lsb_lp  = data_lsb_lp + d_lp;
  localparam int op_lsb_lp    = addr_lsb_lp + a_lp;

  localparam logic [a_lp-1:0] half_lp = {1'b1, {(a_lp-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, SEND, DONE} state_e;

  state_e state_reg, state_next;

  logic                    in_v, ds_ready, out_v, out_ready;
  logic [pkt_width_lp-1:0] in_pkt, out_pkt;
  logic [x_lp-1:0]         in_dst_x;
  logic [y_lp-1:0]         in_dst_y;
  logic [d_lp-1:0]         in_data;
  logic [a_lp-1:0]         in_addr, in_n, n_clamped;
  logic [1:0]              in_op;
  logic                    in_accept, dst_match, is_store, is_start;
  logic                    unused_src_bits;

  logic [d_lp-1:0] mem [0:(1<<a_lp)-1];
  logic [d_lp-1:0] a_reg, b_reg, acc_reg, prod, send_data;
  logic [a_lp-1:0] n_reg, issued_reg, r_reg;
  logic            rd_valid_reg, issue;

  assign in_v     = link_sif_i[link_width_lp-1];
  assign in_pkt   = link_sif_i[link_width_lp-2:1];
  assign ds_ready = link_sif_i[0];

  assign in_dst_x = in_pkt[dst_x_lsb_lp +: x_lp];
  assign in_dst_y = in_pkt[dst_y_lsb_lp +: y_lp];
  assign in_data  = in_pkt[data_lsb_lp +: d_lp];
  assign in_addr  = in_pkt[addr_lsb_lp +: a_lp];
  assign in_op    = in_pkt[op_lsb_lp +: 2];
  assign unused_src_bits = ^{in_pkt[src_x_lsb_lp +: x_lp], in_pkt[src_y_lsb_lp +: y_lp]};

  // Input is only taken while idle or done; misrouted packets are still consumed.
  assign out_ready = (state_reg == IDLE) || (state_reg == DONE);
  assign out_v     = (state_reg == SEND);
  assign in_accept = in_v && out_ready;
  assign dst_match = (in_dst_x == my_x_i) && (in_dst_y == my_y_i);
  assign is_store  = in_accept && dst_match && (in_op == 2'b00);
  assign is_start  = in_accept && dst_match && (in_op == 2'b01);

  assign in_n      = in_data[a_lp-1:0];
  assign n_clamped = (in_n > half_lp) ? half_lp : in_n;

  assign issue = (state_reg == COMPUTE) && (issued_reg < n_reg);
  // Low D bits of the product are identical for signed and unsigned operands.
  assign prod  = $signed(a_reg) * $signed(b_reg);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (is_start) state_next = COMPUTE;
      // Last read already issued: the final MAC lands on the same edge we leave.
      COMPUTE:    if (issued_reg == n_reg) state_next = SEND;
      SEND:       if (ds_ready) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_reg      <= '0;
      n_reg        <= '0;
      issued_reg   <= '0;
      r_reg        <= '0;
      rd_valid_reg <= 1'b0;
    end else if (is_start) begin
      acc_reg      <= '0;
      n_reg        <= n_clamped;
      issued_reg   <= '0;
      r_reg        <= in_addr;
      rd_valid_reg <= 1'b0;
    end else if (state_reg == COMPUTE) begin
      if (issue) issued_reg <= issued_reg + a_lp'(1);
      rd_valid_reg <= issue;
      if (rd_valid_reg) acc_reg <= acc_reg + prod;
    end else begin
      rd_valid_reg <= 1'b0;
    end
  end

  // Block RAM: one write port for STOREs, two registered read ports for the operand pair.
  always_ff @(posedge clk_i) begin
    if (is_store) mem[in_addr] <= in_data;
    a_reg <= mem[issued_reg];
    b_reg <= mem[issued_reg + half_lp];
  end

`ifdef MESH_NN_RELU_EN
  assign send_data = acc_reg[d_lp-1] ? '0 : acc_reg;
`else
  assign send_data = acc_reg;
`endif

  assign out_pkt    = {2'b00, r_reg, send_data, my_y_i, my_x_i, dest_y_i, dest_x_i};
  assign link_sif_o = {out_v, out_pkt, out_ready};
  assign finish_o   = (state_reg == DONE);

endmodule

// File: tb/tb_mesh_nn_accelerator.sv
// Randomized bench for mesh_nn_accelerator against a dot-product memory model.
module tb_mesh_nn_accelerator;
  localparam int X = 2, Y = 2, D = 32, A = 10;
  localparam int P = 2 + A + D + 2*X + 2*Y;
  localparam int L = P + 2;
  localparam int H = 512;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [L-1:0]  link_sif_i, link_sif_o;
  logic [X-1:0]  my_x = 2'd0, dest_x = 2'd1;
  logic [Y-1:0]  my_y = 2'd0, dest_y = 2'd1;
  logic          finish;

  logic          in_v, in_ready;
  logic [P-1:0]  in_pkt;
  wire           out_v     = link_sif_o[L-1];
  wire [P-1:0]   out_pkt   = link_sif_o[L-2:1];
  wire           out_ready = link_sif_o[0];

  assign link_sif_i = {in_v, in_pkt, in_ready};

  int checks = 0;
  int errors = 0;
  logic [D-1:0] model_mem [0:1023];

  always #5 clk = ~clk;

  mesh_nn_accelerator dut (
    .clk_i(clk), .reset_i(reset_i), .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y), .finish_o(finish)
  );

  function automatic logic [P-1:0] make_pkt(input logic [1:0] op, input logic [A-1:0] addr,
      input logic [D-1:0] data, input logic [1:0] sy, input logic [1:0] sx,
      input logic [1:0] dy, input logic [1:0] dx);
    return {op, addr, data, sy, sx, dy, dx};
  endfunction

  function automatic logic [D-1:0] model_dot(input int n);
    logic [D-1:0] acc;
    longint p;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(model_mem[i])) * longint'($signed(model_mem[H+i]));
      acc = acc + p[31:0];
    end
`ifdef MESH_NN_RELU_EN
    if (acc[D-1]) acc = '0;
`endif
    return acc;
  endfunction

  // Every task starts and ends just after a falling edge.
  task automatic drive(input logic [1:0] op, input logic [A-1:0] addr, input logic [D-1:0] data,
                       input logic [1:0] dx, input logic [1:0] dy);
    in_v = 1'b1;
    in_pkt = make_pkt(op, addr, data, 2'd0, 2'd0, dy, dx);
    @(negedge clk);
    in_v = 1'b0;
  endtask

  task automatic store(input int addr, input logic [D-1:0] data);
    drive(2'd0, A'(addr), data, 2'd0, 2'd0);
    model_mem[addr] = data;
  endtask

  task automatic wait_send(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 1200; k++) begin
      if (out_v) begin
        got = 1'b1;
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    in_v = 1'b0;
    in_ready = 1'b1;
    in_pkt = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b want 0", out_v); end
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready got %b want 1", out_ready); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
    $display("test_reset done");
  endtask

  task automatic test_dot_product();
    bit got; int cyc;
    logic [P-1:0] exp_pkt;
    store(0, 32'd3); store(512, 32'd4); store(1, 32'd5); store(513, -32'sd2);
    drive(2'd1, 10'd7, 32'd2, 2'd0, 2'd0);
    wait_send(got, cyc);
    exp_pkt = make_pkt(2'd0, 10'd7, 32'd2, 2'd0, 2'd0, 2'd1, 2'd1);
    checks++; if (!got || cyc > 5) begin errors++; $display("FAIL dot_latency got %0d want <=5", cyc); end
    checks++; if (out_pkt !== exp_pkt) begin errors++; $display("FAIL dot_pkt got %h want %h", out_pkt, exp_pkt); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL dot_finish_in_send got %b want 0", finish); end
    @(negedge clk);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL dot_finish got %b want 1", finish); end
    checks++; if (out_v !== 1'b0 || out_ready !== 1'b1) begin
      errors++; $display("FAIL dot_done_handshake got v=%b rdy=%b want v=0 rdy=1", out_v, out_ready); end
    $display("test_dot_product pkt=%h", exp_pkt);
  endtask

  task automatic test_zero_len();
    bit got; int cyc;
    logic [A-1:0] r;
    logic [P-1:0] exp_pkt;
    r = A'($urandom());
    drive(2'd1, r, 32'd0, 2'd0, 2'd0);
    wait_send(got, cyc);
    exp_pkt = make_pkt(2'd0, r, 32'd0, 2'd0, 2'd0, 2'd1, 2'd1);
    checks++; if (!got || cyc > 3) begin errors++; $display("FAIL zero_latency got %0d want <=3", cyc); end
    checks++; if (out_pkt !== exp_pkt) begin errors++; $display("FAIL zero_pkt got %h want %h", out_pkt, exp_pkt); end
    @(negedge clk);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL zero_finish got %b want 1", finish); end
    $display("test_zero_len addr=%0d", r);
  endtask

  task automatic test_negative();
    bit got; int cyc;
    logic [D-1:0] exp_data;
    store(0, 32'hFFFF_FFFF); store(512, 32'd5);
`ifdef MESH_NN_RELU_EN
    exp_data = 32'd0;
`else
    exp_data = 32'hFFFF_FFFB;
`endif
    drive(2'd1, 10'd3, 32'd1, 2'd0, 2'd0);
    wait_send(got, cyc);
    checks++; if (!got || out_pkt[D+7:8] !== exp_data) begin
      errors++; $display("FAIL neg_data got %h want %h", out_pkt[D+7:8], exp_data); end
    @(negedge clk);
    $display("test_negative data=%h", exp_data);
  endtask

  task automatic test_backpressure();
    bit got; int cyc;
    logic [D-1:0] a, b, exp_data;
    logic [P-1:0] held;
    a = $urandom(); b = $urandom();
    store(0, a); store(512, b);
    exp_data = model_dot(1);
    in_ready = 1'b0;
    drive(2'd1, 10'd9, 32'd1, 2'd0, 2'd0);
    wait_send(got, cyc);
    held = out_pkt;
    checks++; if (!got || held[D+7:8] !== exp_data) begin
      errors++; $display("FAIL bp_data got %h want %h", held[D+7:8], exp_data); end
    // A STORE offered while the result is blocked must not be taken.
    in_v = 1'b1;
    in_pkt = make_pkt(2'd0, 10'd0, ~a, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_v !== 1'b1 || out_pkt !== held || out_ready !== 1'b0 || finish !== 1'b0) begin
        errors++; $display("FAIL bp_hold got v=%b pkt=%h rdy=%b fin=%b want v=1 pkt=%h rdy=0 fin=0",
                           out_v, out_pkt, out_ready, finish, held); end
      @(negedge clk);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_v = 1'b0;
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL bp_finish got %b want 1", finish); end
    drive(2'd1, 10'd9, 32'd1, 2'd0, 2'd0);
    wait_send(got, cyc);
    checks++; if (!got || out_pkt[D+7:8] !== exp_data) begin
      errors++; $display("FAIL bp_store_rejected got %h want %h", out_pkt[D+7:8], exp_data); end
    @(negedge clk);
    $display("test_backpressure data=%h", exp_data);
  endtask

  task automatic test_wrong_dst();
    bit got; int cyc;
    logic [D-1:0] exp_data;
    store(0, $urandom()); store(512, $urandom());
    drive(2'd0, 10'd0, $urandom(), 2'd0, 2'd1);
    drive(2'd0, 10'd512, $urandom(), 2'd1, 2'd0);
    drive(2'd2, 10'd0, $urandom(), 2'd0, 2'd0);
    drive(2'd3, 10'd512, $urandom(), 2'd0, 2'd0);
    exp_data = model_dot(1);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL wd_finish_kept got %b want 1", finish); end
    drive(2'd1, 10'd11, 32'd1, 2'd0, 2'd0);
    wait_send(got, cyc);
    checks++; if (!got || out_pkt[D+7:8] !== exp_data) begin
      errors++; $display("FAIL wd_data got %h want %h", out_pkt[D+7:8], exp_data); end
    @(negedge clk);
    $display("test_wrong_dst data=%h", exp_data);
  endtask

  task automatic test_back_to_back();
    bit got; int cyc, n;
    logic [A-1:0] r;
    logic [D-1:0] sd;
    logic [P-1:0] exp_pkt;
    for (int it = 0; it < 8; it++) begin
      n = (it == 7) ? $urandom_range(513, 1023) : $urandom_range(0, 24);
      for (int i = 0; i < ((n > H) ? H : n); i++) begin
        store(i, $urandom()); store(H + i, $urandom());
        if ($urandom_range(0, 3) == 0) drive(2'($urandom_range(0, 3)), A'(i), $urandom(), 2'd1, 2'd1);
      end
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL b2b_finish_held got %b want 1", finish); end
      r = A'($urandom());
      sd = $urandom();
      sd[A-1:0] = A'(n);
      drive(2'd1, r, sd, 2'd0, 2'd0);
      if (n > H) n = H;
      wait_send(got, cyc);
      exp_pkt = make_pkt(2'd0, r, model_dot(n), 2'd0, 2'd0, 2'd1, 2'd1);
      checks++; if (!got || cyc > n + 3) begin errors++; $display("FAIL b2b_latency n=%0d got %0d want <=%0d", n, cyc, n + 3); end
      checks++; if (out_pkt !== exp_pkt) begin errors++; $display("FAIL b2b_pkt n=%0d got %h want %h", n, out_pkt, exp_pkt); end
      @(negedge clk);
      $display("test_back_to_back n=%0d addr=%0d data=%h", n, r, exp_pkt[D+7:8]);
    end
  endtask

  task automatic test_reset_mid();
    bit got, saw_v; int cyc;
    drive(2'd1, 10'd1, 32'd512, 2'd0, 2'd0);
    repeat (10) @(negedge clk);
    checks++; if (out_ready !== 1'b0 || finish !== 1'b0) begin
      errors++; $display("FAIL mid_compute got rdy=%b fin=%b want 0 0", out_ready, finish); end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checks++; if (finish !== 1'b0 || out_v !== 1'b0 || out_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got fin=%b v=%b rdy=%b want 0 0 1", finish, out_v, out_ready); end
    saw_v = 1'b0;
    repeat (600) begin
      if (out_v) saw_v = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_v !== 1'b0) begin errors++; $display("FAIL mid_no_result got %b want 0", saw_v); end
    drive(2'd1, 10'd2, 32'd2, 2'd0, 2'd0);
    wait_send(got, cyc);
    checks++; if (!got || out_pkt[D+7:8] !== model_dot(2)) begin
      errors++; $display("FAIL mid_mem_kept got %h want %h", out_pkt[D+7:8], model_dot(2)); end
    @(negedge clk);
    $display("test_reset_mid done");
  endtask

  initial begin
    reset_i = 1'b1;
    in_v = 1'b0;
    in_ready = 1'b1;
    in_pkt = '0;
    @(negedge clk);
    test_reset();
    test_dot_product();
    test_zero_len();
    test_negative();
    test_backpressure();
    test_wrong_dst();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
